// File: rtl/commit_trace_buffer_if.sv
// Commit/read bus between the core-side driver (master) and commit_trace_buffer (slave).
// rd_data layout: {inum[31:0], kind[1:0], is_load, pc[15:0], reg[3:0], value[15:0], addr[15:0]}.
interface commit_trace_buffer_if;
   logic        commit_valid;
   logic [15:0] commit_pc;
   logic        reg_write;
   logic [3:0]  wr_reg;
   logic [15:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        halt;
   logic        rd_en;
   logic        rd_valid;
   logic [86:0] rd_data;

   modport master (
      output commit_valid, commit_pc, reg_write, wr_reg, write_data,
             mem_read, mem_write, mem_addr, mem_data, halt, rd_en,
      input  rd_valid, rd_data
   );

   modport slave (
      input  commit_valid, commit_pc, reg_write, wr_reg, write_data,
             mem_read, mem_write, mem_addr, mem_data, halt, rd_en,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: packs each commit into a record, queues it in a FIFO, and tracks counters.
// Optional macro TRACE_NOP_FILTER_EN: kind-0 (branch/NOP) commits are counted but not enqueued.
module commit_trace_buffer #(
   parameter int DEPTH       = 16,
   parameter int CYCLE_LIMIT = 100000,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   commit_trace_buffer_if.slave bus,
   output logic [CNT_W-1:0]     inst_count,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 overflow,
   output logic                 done,
   output logic                 timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_TIMEOUT} state_t;

   state_t        state, state_next;
   logic [86:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   logic          empty, full, accept, enq_req, push, pop, drop;
   logic [1:0]    kind;
   logic          is_load;
   logic [3:0]    rec_reg;
   logic [15:0]   rec_value, rec_addr;
   logic [86:0]   record;
   logic [CNT_W-1:0] cycle_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + CNT_W'(1);
   endfunction

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign accept = bus.commit_valid && (state == ST_RUN);
   assign pop    = bus.rd_en && !empty;

   // Record packing; halt outranks store, store outranks plain register write.
   always_comb begin
      kind      = 2'd0;
      rec_reg   = 4'd0;
      rec_value = 16'd0;
      rec_addr  = 16'd0;
      is_load   = bus.mem_read && bus.reg_write;
      if (bus.halt)           kind = 2'd3;
      else if (bus.mem_write) kind = 2'd2;
      else if (bus.reg_write) kind = 2'd1;
      if (kind == 2'd1) begin
         rec_reg   = bus.wr_reg;
         rec_value = bus.write_data;
      end else if (kind == 2'd2) begin
         rec_value = bus.mem_data;
      end
      if (kind == 2'd2 || is_load) rec_addr = bus.mem_addr;
   end

   assign record = {32'(inst_count), kind, is_load, bus.commit_pc, rec_reg, rec_value, rec_addr};

`ifdef TRACE_NOP_FILTER_EN
   assign enq_req = accept && (kind != 2'd0);
`else
   assign enq_req = accept;
`endif

   // A same-cycle pop frees the slot, so a full FIFO only drops when nobody reads.
   assign push = enq_req && (!full || pop);
   assign drop = enq_req && full && !pop;

   assign cycle_inc = sat_inc(cycle_count);

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (accept && bus.halt)
               state_next = ST_HALTED;
            else if (CYCLE_LIMIT != 0 && cycle_inc == CNT_W'(CYCLE_LIMIT))
               state_next = ST_TIMEOUT;
         end
         default: state_next = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         inst_count  <= '0;
         cycle_count <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_RUN) cycle_count <= cycle_inc;
         if (accept)          inst_count  <= sat_inc(inst_count);
         if (push)            wr_ptr      <= wr_ptr + PW'(1);
         if (pop)             rd_ptr      <= rd_ptr + PW'(1);
         if (drop) begin
            drop_count <= sat_inc(drop_count);
            overflow   <= 1'b1;
         end
      end
   end

   // Storage needs no reset; validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr[AW-1:0]] <= record;
   end

   assign bus.rd_valid = !empty;
   assign bus.rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign done         = (state != ST_RUN);
   assign timeout      = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_commit_trace_buffer;

   localparam int DEPTH = 4;
   localparam int LIMIT = 50;

   logic        clk;
   logic        rst;
   logic [31:0] inst_count, cycle_count, drop_count;
   logic        overflow, done, timeout;

   int checks   = 0;
   int failures = 0;

   // Model: status as plain integers, FIFO as a bounded queue.
   logic [86:0] m_q[$];
   logic [31:0] m_inst, m_cycle, m_drop;
   bit          m_ovf;
   int          m_state;

   commit_trace_buffer_if tif();

   commit_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .bus(tif),
      .inst_count(inst_count), .cycle_count(cycle_count), .drop_count(drop_count),
      .overflow(overflow), .done(done), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sat(input logic [31:0] x);
      return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
   endfunction

   task automatic chk(input string tag, input logic [86:0] obs, input logic [86:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [1:0]  k;
      logic        ld;
      logic [3:0]  r;
      logic [15:0] v, a;
      logic [86:0] rec;
      bit          keep;
      if (rst) begin
         m_q.delete();
         m_inst = 0; m_cycle = 0; m_drop = 0; m_ovf = 0; m_state = 0;
         return;
      end
      if (tif.rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (m_state == 0) begin
         m_cycle = sat(m_cycle);
         if (tif.commit_valid) begin
            k  = tif.halt ? 2'd3 : tif.mem_write ? 2'd2 : tif.reg_write ? 2'd1 : 2'd0;
            ld = tif.mem_read & tif.reg_write;
            r  = (k == 2'd1) ? tif.wr_reg : 4'd0;
            v  = (k == 2'd1) ? tif.write_data : (k == 2'd2) ? tif.mem_data : 16'd0;
            a  = (k == 2'd2 || ld) ? tif.mem_addr : 16'd0;
            rec = {m_inst, k, ld, tif.commit_pc, r, v, a};
            m_inst = sat(m_inst);
`ifdef TRACE_NOP_FILTER_EN
            keep = (k != 2'd0);
`else
            keep = 1'b1;
`endif
            if (keep) begin
               if (m_q.size() < DEPTH) m_q.push_back(rec);
               else begin
                  m_drop = sat(m_drop);
                  m_ovf  = 1'b1;
               end
            end
            if (tif.halt) m_state = 1;
         end
         if (m_state == 0 && m_cycle == LIMIT) m_state = 2;
      end
   endtask

   task automatic check_output();
      logic [86:0] exp_data;
      exp_data = (m_q.size() != 0) ? m_q[0] : '0;
      chk("rd_valid", tif.rd_valid, m_q.size() != 0);
      chk("rd_data", tif.rd_data, exp_data);
      chk("inst_count", inst_count, m_inst);
      chk("cycle_count", cycle_count, m_cycle);
      chk("drop_count", drop_count, m_drop);
      chk("overflow", overflow, m_ovf);
      chk("done", done, m_state != 0);
      chk("timeout", timeout, m_state == 2);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_output();
   endtask

   task automatic idle();
      tif.commit_valid = 0; tif.commit_pc = 0; tif.reg_write = 0; tif.wr_reg = 0;
      tif.write_data = 0; tif.mem_read = 0; tif.mem_write = 0; tif.mem_addr = 0;
      tif.mem_data = 0; tif.halt = 0; tif.rd_en = 0;
   endtask

   task automatic apply_stimulus(input logic [15:0] pc, input logic rw, input logic [3:0] rg,
                                 input logic [15:0] wd, input logic mr, input logic mw,
                                 input logic [15:0] ma, input logic [15:0] md, input logic h);
      tif.commit_valid = 1; tif.commit_pc = pc; tif.reg_write = rw; tif.wr_reg = rg;
      tif.write_data = wd; tif.mem_read = mr; tif.mem_write = mw; tif.mem_addr = ma;
      tif.mem_data = md; tif.halt = h;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle();
      tick();
      tick();
      chk("reset_rd_data", tif.rd_data, '0);
      rst = 0;

      // Register write, then read back
      apply_stimulus(16'h0002, 1, 4'd3, 16'h00A5, 0, 0, 16'h0, 16'h0, 0);
      tick();
      idle();
      chk("regwr_record", tif.rd_data, {32'd0, 2'd1, 1'b0, 16'h0002, 4'd3, 16'h00A5, 16'h0000});
      chk("regwr_inst", inst_count, 32'd1);
      tif.rd_en = 1;
      tick();
      idle();

      // Load then store
      apply_stimulus(16'h0004, 1, 4'd2, 16'h1234, 1, 0, 16'h0010, 16'h0, 0);
      tick();
      apply_stimulus(16'h0006, 0, 4'd0, 16'h0, 0, 1, 16'h0020, 16'hBEEF, 0);
      tick();
      idle();
      chk("load_record", tif.rd_data, {32'd1, 2'd1, 1'b1, 16'h0004, 4'd2, 16'h1234, 16'h0010});
      tif.rd_en = 1;
      tick();
      chk("store_record", tif.rd_data, {32'd2, 2'd2, 1'b0, 16'h0006, 4'd0, 16'hBEEF, 16'h0020});
      tick();
      idle();
      chk("drained", tif.rd_valid, 1'b0);

      // Overflow with no reads, then a full FIFO with simultaneous pop and commit
      do_reset();
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(16'(2 * i), 1, 4'(i), 16'(i + 16'h100), 0, 0, 16'h0, 16'h0, 0);
         tick();
      end
      chk("ovf_drop", drop_count, 32'd2);
      chk("ovf_flag", overflow, 1'b1);
      chk("ovf_inst", inst_count, 32'd6);
      apply_stimulus(16'h0040, 1, 4'd7, 16'h7777, 0, 0, 16'h0, 16'h0, 0);
      tif.rd_en = 1;
      tick();
      idle();
      chk("ovf_no_drop", drop_count, 32'd2);
      chk("ovf_inst2", inst_count, 32'd7);

      // Halt after three commits; later commits ignored
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(16'(2 * i), 1, 4'd1, 16'(i), 0, 0, 16'h0, 16'h0, 0);
         tick();
      end
      apply_stimulus(16'h000A, 0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
      tick();
      chk("halt_done", done, 1'b1);
      apply_stimulus(16'h000C, 1, 4'd5, 16'h5555, 0, 0, 16'h0, 16'h0, 0);
      tick();
      tick();
      chk("halt_inst", inst_count, 32'd4);
      chk("halt_cycle", cycle_count, 32'd4);
      idle();
      tif.rd_en = 1;
      for (int i = 0; i < 3; i++) tick();
      chk("halt_record", tif.rd_data, {32'd3, 2'd3, 1'b0, 16'h000A, 4'd0, 16'h0000, 16'h0000});
      idle();

      // Timeout at the cycle limit, then reset with a commit in the same cycle
      do_reset();
      for (int i = 0; i < LIMIT - 1; i++) tick();
      chk("pre_timeout", timeout, 1'b0);
      tick();
      chk("timeout", timeout, 1'b1);
      chk("timeout_done", done, 1'b1);
      chk("timeout_cycle", cycle_count, 32'd50);
      for (int i = 0; i < 3; i++) tick();
      chk("timeout_frozen", cycle_count, 32'd50);
      apply_stimulus(16'h0100, 1, 4'd9, 16'h9999, 0, 0, 16'h0, 16'h0, 0);
      rst = 1;
      tick();
      rst = 0;
      idle();
      chk("rst_inst", inst_count, 32'd0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_rd_valid", tif.rd_valid, 1'b0);

      // NOP commits: filtered out or recorded depending on build
      do_reset();
      apply_stimulus(16'h0010, 0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      tick();
      apply_stimulus(16'h0012, 1, 4'd4, 16'h0044, 0, 0, 16'h0, 16'h0, 0);
      tick();
      apply_stimulus(16'h0014, 0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      tick();
      idle();
      chk("nop_inst", inst_count, 32'd3);
`ifdef TRACE_NOP_FILTER_EN
      chk("filter_record", tif.rd_data, {32'd1, 2'd1, 1'b0, 16'h0012, 4'd4, 16'h0044, 16'h0000});
`else
      chk("nop_record", tif.rd_data, {32'd0, 2'd0, 1'b0, 16'h0010, 4'd0, 16'h0000, 16'h0000});
`endif

      // Random traffic with occasional halts and resets
      do_reset();
      for (int i = 0; i < 600; i++) begin
         tif.commit_valid = 1'($urandom_range(0, 1));
         tif.commit_pc    = 16'($urandom);
         tif.reg_write    = 1'($urandom_range(0, 1));
         tif.wr_reg       = 4'($urandom);
         tif.write_data   = 16'($urandom);
         tif.mem_read     = 1'($urandom_range(0, 1));
         tif.mem_write    = ($urandom_range(0, 3) == 0);
         tif.mem_addr     = 16'($urandom);
         tif.mem_data     = 16'($urandom);
         tif.halt         = ($urandom_range(0, 29) == 0);
         tif.rd_en        = ($urandom_range(0, 2) == 0);
         rst              = ($urandom_range(0, 39) == 0);
         tick();
      end
      rst = 0;
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable retire-trace capture block for the CPU. It sits beside the core, samples one commit event per cycle (PC, register write, memory access, halt), tags it with an instruction number, and queues a packed record in a parametrised FIFO for a host or bench to drain. It also keeps instruction and cycle counters, stops on halt or a cycle-limit timeout, and counts records dropped on overflow.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- CYCLE_LIMIT, 100000, cycles in RUN before forcing TIMEOUT; 0 disables the limit
- CNT_W, 32, width of inst_count, cycle_count and drop_count
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  16  PC of the retiring instruction
- reg_write  in  1  instruction writes the register file
- wr_reg  in  4  destination register
- write_data  in  16  register write value
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- mem_addr  in  16  memory address (ALU result)
- mem_data  in  16  store data
- halt  in  1  retiring instruction is HLT
- rd_en  in  1  pop head record
- rd_valid  out  1  head record present
- rd_data  out  87  head record: {inum[31:0], kind[1:0], is_load, pc[15:0], reg[3:0], value[15:0], addr[15:0]}
- inst_count  out  CNT_W  instructions committed
- cycle_count  out  CNT_W  cycles spent in RUN
- drop_count  out  CNT_W  records lost to FIFO full
- overflow  out  1  sticky; set on first drop
- done  out  1  state is HALTED or TIMEOUT
- timeout  out  1  state is TIMEOUT

## Operation
- States: RUN (entered on reset), HALTED, TIMEOUT. RUN→HALTED on commit_valid&halt. RUN→TIMEOUT when cycle_count reaches CYCLE_LIMIT. HALTED and TIMEOUT hold until rst.
- Kind encoding: 3 = halt (halt has priority), 2 = store (mem_write), 1 = register write (reg_write), 0 = branch/NOP. is_load = mem_read&reg_write.
- Field rules: reg and value come from wr_reg/write_data for kind 1, otherwise zero. For kind 2, value = mem_data and addr = mem_addr. addr = mem_addr also when is_load. All unused fields are zero.
- inum = inst_count before the increment, so the first commit after reset gets inum 0. inst_count increments on every commit_valid in RUN, including dropped and filtered commits.
- Commits outside RUN are ignored: no record and no count.
- FIFO full when a commit arrives: the record is dropped, drop_count increments, and overflow sets. A halt still moves the state to HALTED.
- Full FIFO with rd_en and a commit in the same cycle: the pop frees a slot, so the write is accepted with no drop.
- rd_en while rd_valid is 0: ignored.
- Counters saturate at all-ones and never wrap. Pointers are log2(DEPTH)+1 bits and wrap naturally.

## Timing
- Reset values: rd_valid 0, rd_data 0, all counters 0, overflow 0, done 0, timeout 0, state RUN, FIFO empty.
- Record latency: a commit at edge N is visible on rd_data/rd_valid after edge N (registered, no fall-through).
- Read: when rd_valid&rd_en is high at an edge, the next record (or rd_valid=0) appears after that edge.
- cycle_count increments every cycle in RUN, including the cycle a halt commits. It freezes in HALTED and TIMEOUT.
- rst mid-operation: the FIFO is flushed and all state returns to reset values at that edge. The commit in the same cycle is discarded.
- The FIFO keeps draining after done; done does not block reads.

## Configuration
- TRACE_NOP_FILTER_EN defined: kind-0 commits are counted in inst_count but not enqueued. Their inum values are skipped in the record stream.
- TRACE_NOP_FILTER_EN undefined: every commit in RUN is enqueued.

## Test plan
- Reg write then read: commit pc=0x0002, wr_reg=3, write_data=0x00A5 → after 1 cycle rd_data gives inum 0, kind 1, reg 3, value 0x00A5. inst_count = 1.
- Load and store: load pc=0x0004, reg 2, data 0x1234, addr 0x0010, then store addr 0x0020, data 0xBEEF → two records: kind 1 is_load=1 addr 0x0010, then kind 2 value 0xBEEF addr 0x0020.
- Overflow, DEPTH=4, no reads: 6 commits → 4 records stored, drop_count 2, overflow 1, inst_count 6. Then a full FIFO with rd_en and a commit in the same cycle → no further drop.
- Halt: 3 commits then halt at pc=0x000A → last record kind 3, inum 3, done=1. Further commits leave inst_count at 4 and cycle_count frozen.
- Timeout, CYCLE_LIMIT=50, no halt: done and timeout go high once cycle_count = 50. Mid-run rst → all outputs return to reset values on the next edge.
- Filter, TRACE_NOP_FILTER_EN defined: commits of NOP, reg write, NOP → one record with inum 1, inst_count 3.
